// File: rtl/rv32i_dmem_responder.sv
// rtl/rv32i_dmem_responder.sv - RV32i dmem responder: word RAM, byte-lane writes, wait states, range error
module rv32i_dmem_responder #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_2000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] dmem_add_i,
    input  logic [31:0] dmem_di_i,
    input  logic        dmem_we_i,
    input  logic        dmem_re_i,
    input  logic [3:0]  dmem_ble_i,
    output logic [31:0] dmem_do_o,
    output logic        dmem_ready_o,
    output logic        dmem_err_o,
    output logic        busy_o
);
    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES > 0 ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic [31:0] r_add;
    logic [31:0] r_di;
    logic        r_we;
    logic        r_re;
    logic [3:0]  r_ble;
    logic [31:0] r_do;
    logic        r_ready;
    logic        r_err;
    logic [31:0] r_mem [0:DEPTH_WORDS-1];

    logic          w_req;
    logic          w_go_idle;
    logic          w_go_wait;
    logic          w_acc;
    logic [31:0]   w_a_add;
    logic [31:0]   w_a_di;
    logic          w_a_we;
    logic          w_a_re;
    logic [3:0]    w_a_ble;
    logic          w_in_range;
    logic [AW-1:0] w_idx;

    assign w_req = dmem_we_i | dmem_re_i;

    // The access happens on the edge that enters RESP, so read data is valid
    // alongside ready. With no wait states that edge is the accepting one,
    // hence the live inputs are used instead of the captured copy.
    assign w_go_idle = (r_state == S_IDLE) && w_req && (WAIT_STATES == 0);
    assign w_go_wait = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign w_acc     = !rst_i && (w_go_idle || w_go_wait);

    assign w_a_add = w_go_idle ? dmem_add_i : r_add;
    assign w_a_di  = w_go_idle ? dmem_di_i  : r_di;
    assign w_a_we  = w_go_idle ? dmem_we_i  : r_we;
    assign w_a_re  = w_go_idle ? dmem_re_i  : r_re;
    assign w_a_ble = w_go_idle ? dmem_ble_i : r_ble;

    assign w_in_range = ({1'b0, w_a_add} >= {1'b0, BASE_ADDR}) && ({1'b0, w_a_add} < LIMIT);
    assign w_idx      = AW'((w_a_add - BASE_ADDR) >> 2);

    always_ff @(posedge clk_i) begin
        if (w_acc && w_a_we && w_in_range) begin
            for (int n = 0; n < 4; n++) begin
                if (w_a_ble[n]) begin
                    r_mem[w_idx][8*n +: 8] <= w_a_di[8*n +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_add   <= 32'd0;
            r_di    <= 32'd0;
            r_we    <= 1'b0;
            r_re    <= 1'b0;
            r_ble   <= 4'd0;
            r_do    <= 32'd0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_add <= dmem_add_i;
                        r_di  <= dmem_di_i;
                        r_we  <= dmem_we_i;
                        r_re  <= dmem_re_i;
                        r_ble <= dmem_ble_i;
                        if (WAIT_STATES > 0) begin
                            r_state <= S_WAIT;
                            r_cnt   <= WS_LOAD;
                        end else begin
                            r_state <= S_RESP;
                        end
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
            if (w_acc) begin
                r_ready <= 1'b1;
                r_err   <= !w_in_range;
                if (!w_in_range) begin
                    r_do <= 32'd0;
                end else if (w_a_re) begin
                    r_do <= r_mem[w_idx];
                end
            end
        end
    end

    assign dmem_do_o    = r_do;
    assign dmem_ready_o = r_ready;
    assign dmem_err_o   = r_err;
    assign busy_o       = !rst_i && ((r_state != S_IDLE) || w_req);

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// tb/tb_rv32i_dmem_responder.sv - scoreboard bench for rv32i_dmem_responder at 0, 2 and 3 wait states
module tb_rv32i_dmem_responder;
    typedef struct {
        int          unit;
        logic [31:0] do_v;
        logic        err;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic [2:0]  rst = 3'b111;
    logic [2:0]  we  = 3'b000;
    logic [2:0]  re  = 3'b000;
    logic [2:0]  rdy;
    logic [2:0]  errs;
    logic [2:0]  busy;
    logic [31:0] add  [3];
    logic [31:0] di   [3];
    logic [31:0] dout [3];
    logic [3:0]  ble  [3];

    logic [31:0] mdl [3][16];
    logic [31:0] last_do [3];
    exp_t        sb [$];
    int          checks = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        rv32i_dmem_responder #(
            .DEPTH_WORDS(16),
            .BASE_ADDR  (32'h0000_2000),
            .WAIT_STATES(g == 0 ? 0 : g + 1)
        ) u_dut (
            .clk_i       (clk),
            .rst_i       (rst[g]),
            .dmem_add_i  (add[g]),
            .dmem_di_i   (di[g]),
            .dmem_we_i   (we[g]),
            .dmem_re_i   (re[g]),
            .dmem_ble_i  (ble[g]),
            .dmem_do_o   (dout[g]),
            .dmem_ready_o(rdy[g]),
            .dmem_err_o  (errs[g]),
            .busy_o      (busy[g])
        );
    end

    function automatic int ws_of(input int u);
        return (u == 0) ? 0 : u + 1;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Model the access and queue its expected response.
    task automatic expect_resp(input int u, input logic w, input logic r,
                               input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        exp_t e;
        logic inr;
        int   idx;
        inr = (a >= 32'h2000) && (a < 32'h2040);
        idx = int'((a - 32'h2000) >> 2);
        e.unit = u;
        e.err  = !inr;
        e.lat  = 1 + ws_of(u);
        if (!inr)   e.do_v = 32'd0;
        else if (r) e.do_v = mdl[u][idx];
        else        e.do_v = last_do[u];
        if (inr && w) begin
            for (int n = 0; n < 4; n++)
                if (b[n]) mdl[u][idx][8*n +: 8] = d[8*n +: 8];
        end
        last_do[u] = e.do_v;
        sb.push_back(e);
    endtask

    task automatic check_resp(input int u, input int lat);
        exp_t e;
        check_eq("sb_depth", sb.size(), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        check_eq("ready", {31'd0, rdy[u]}, 1);
        check_eq("busy_at_ready", {31'd0, busy[u]}, 1);
        check_eq("err", {31'd0, errs[u]}, {31'd0, e.err});
        check_eq("rdata", dout[u], e.do_v);
        check_eq("latency", lat, e.lat);
    endtask

    task automatic req(input int u, input logic w, input logic r,
                       input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        int lat;
        expect_resp(u, w, r, a, d, b);
        @(negedge clk);
        we[u] = w; re[u] = r; add[u] = a; di[u] = d; ble[u] = b;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!rdy[u] && lat < 40);
        we[u] = 1'b0; re[u] = 1'b0;
        check_resp(u, lat);
    endtask

    initial begin
        for (int u = 0; u < 3; u++) begin
            add[u] = 32'd0; di[u] = 32'd0; ble[u] = 4'd0; last_do[u] = 32'd0;
        end
        repeat (3) @(negedge clk);
        for (int u = 0; u < 3; u++) begin
            check_eq("rst_do", dout[u], 32'd0);
            check_eq("rst_flags", {29'd0, rdy[u], errs[u], busy[u]}, 32'd0);
        end
        rst = 3'b000;

        req(0, 1, 0, 32'h2000, 32'hDEADBEEF, 4'hF);
        req(0, 0, 1, 32'h2000, 32'h0, 4'hF);
        req(0, 1, 0, 32'h200C, 32'h11223344, 4'hF);
        req(0, 1, 0, 32'h200C, 32'h00AA0000, 4'b0100);
        req(0, 1, 0, 32'h200C, 32'hFFFFFFFF, 4'b0000);
        req(0, 0, 1, 32'h200C, 32'h0, 4'b0001);
        req(0, 1, 0, 32'h203C, 32'h77778888, 4'hF);
        req(0, 0, 1, 32'h1FFC, 32'h0, 4'hF);
        req(0, 1, 0, 32'h2040, 32'h99999999, 4'hF);
        req(0, 0, 1, 32'h2000, 32'h0, 4'hF);
        req(0, 0, 1, 32'h203C, 32'h0, 4'hF);
        req(0, 1, 0, 32'h2004, 32'h0, 4'hF);
        req(0, 1, 1, 32'h2004, 32'h12345678, 4'hF);
        req(0, 0, 1, 32'h2004, 32'h0, 4'hF);

        // Three wait states: held request, a stray strobe mid-wait is dropped.
        req(2, 1, 0, 32'h2010, 32'h0BADCAFE, 4'hF);
        req(2, 1, 0, 32'h2014, 32'h55AA55AA, 4'hF);
        expect_resp(2, 0, 1, 32'h2010, 32'h0, 4'hF);
        @(negedge clk);
        re[2] = 1'b1; add[2] = 32'h2010; ble[2] = 4'hF;
        #1;
        check_eq("ws3_busy_accept", {31'd0, busy[2]}, 1);
        check_eq("ws3_ready_accept", {31'd0, rdy[2]}, 0);
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq("ws3_busy", {31'd0, busy[2]}, 1);
            if (k < 4) check_eq("ws3_early_ready", {31'd0, rdy[2]}, 0);
            else       check_resp(2, k);
            re[2] = (k == 2);
            if (k == 2) add[2] = 32'h2014;
        end
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            check_eq("ws3_idle_busy", {31'd0, busy[2]}, 0);
            check_eq("ws3_no_ready", {31'd0, rdy[2]}, 0);
        end

        // Two wait states: reset in WAIT must abandon the write.
        req(1, 1, 0, 32'h2008, 32'hCAFEF00D, 4'hF);
        req(1, 0, 1, 32'h2008, 32'h0, 4'hF);
        @(negedge clk);
        we[1] = 1'b1; add[1] = 32'h2008; di[1] = 32'h01020304; ble[1] = 4'hF;
        @(negedge clk);
        rst[1] = 1'b1; we[1] = 1'b0;
        #1;
        check_eq("mid_rst_do", dout[1], 32'd0);
        check_eq("mid_rst_flags", {29'd0, rdy[1], errs[1], busy[1]}, 32'd0);
        @(negedge clk);
        rst[1] = 1'b0;
        last_do[1] = 32'd0;
        repeat (4) begin
            @(negedge clk);
            check_eq("post_rst_no_ready", {31'd0, rdy[1]}, 0);
        end
        req(1, 0, 1, 32'h2008, 32'h0, 4'hF);
        req(1, 1, 1, 32'h2008, 32'h01020304, 4'b0011);
        req(1, 0, 1, 32'h2008, 32'h0, 4'hF);

        check_eq("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
